execute_cycle_md: RTL and testbench
===================================

Name: execute_cycle_md

Overview:
RV32IM execute stage, directly upstream of the memory stage. It performs operand forwarding, the ALU and single-cycle multiply, iterative divide/remainder, and branch/jump resolution. It owns the EX/MEM pipeline register that drives the memory stage's inputs. It raises StallE while a divide is in flight so the hazard unit holds IF/ID/EX.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
EARLY_SPECIAL, 1, when 1, divide-by-zero and signed-overflow divides complete in 1 cycle with no stall; when 0, they run the full iteration.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-low reset (rst=0 resets on posedge clk)
RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE  in  1 each  decoded controls
ResultSrcE  in  2  writeback source select
BranchTypeE  in  3  branch funct3 (BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111)
ALUControlE  in  5  op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; others act as ADD
RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  operands and PC values
RD_E  in  5  destination register
LoadTypeE, StoreTypeE  in  3 each  passed to the memory stage
ForwardA_E, ForwardB_E  in  2 each  00 register file, 01 ResultW, 10 ALU_ResultM
ResultW  in  32  writeback result
FlushE  in  1  squash the instruction in E
PCSrcE  out  1  redirect fetch
PCTargetE  out  32  PCE+Imm_Ext_E, or (SrcA+Imm)&~1 when JumpE&ALUSrcE (JALR)
StallE  out  1  divide in progress; hold upstream stages
RegWriteM, MemWriteM  out  1 each  registered
ResultSrcM  out  2  registered
RD_M  out  5  registered
PCPlus4M, WriteDataM, ALU_ResultM  out  32 each  registered; WriteDataM is forwarded SrcB before the imm mux
LoadTypeM, StoreTypeM  out  3 each  registered

Behaviour:
- Reset (rst=0 at posedge) clears all registered outputs to 0, sets the FSM to IDLE and clears the counter. Combinational outputs are 0 while the FSM is IDLE with rst=0.
- SrcA is the forward mux of RD1_E. SrcB_raw is the forward mux of RD2_E. SrcB = ALUSrcE ? Imm_Ext_E : SrcB_raw.
- Shifts use SrcB[4:0]. SLT and SLTU produce 0 or 1.
- MUL returns the low 32 bits of the 64-bit product. MULH, MULHSU and MULHU return the high 32 bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively. All multiply ops complete in 1 cycle.
- Divide/remainder use a radix-2 restoring divider on magnitudes with sign fixup. Quotient sign = sign(A) XOR sign(B). Remainder takes the sign of the dividend.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
- Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
- Divider FSM:
  - IDLE: a DIV/DIVU/REM/REMU in E that is not an early special case drives StallE=1. At posedge, magnitudes and signs are latched, cnt=0, and the FSM moves to BUSY.
  - BUSY: StallE=1. One iteration per posedge. When cnt==31, the FSM moves to DONE.
  - DONE: StallE=0 and the result is muxed onto the ALU result. At posedge the EX/MEM register captures the result and the FSM returns to IDLE.
  - Total E occupancy is 34 cycles, 33 of them with StallE=1.
- Operands are latched at start, so forwarding-source changes during BUSY are ignored.
- EX/MEM register:
  - When StallE=1 or FlushE=1, a bubble is loaded: RegWriteM=0, MemWriteM=0, and the other fields are don't-care but are driven to 0.
  - Otherwise all E fields are loaded.
- FlushE during BUSY or DONE aborts the divide, returns the FSM to IDLE, drops StallE and loads a bubble.
- Reset mid-divide returns the FSM to IDLE at that posedge.
- PCSrcE = (JumpE | (BranchE & cond)) & ~FlushE. cond uses signed or unsigned compare of SrcA and SrcB_raw.

Test Plan:
- ALU and forwarding: ADD with ForwardA_E=10, ALU_ResultM=5, RD2_E=7 -> next cycle ALU_ResultM=12, RegWriteM=1.
- MULH: SrcA=0x80000000, SrcB=2 -> ALU_ResultM=0xFFFFFFFF after 1 cycle; MULHU with the same operands -> 0x00000001.
- DIV: -7/2 -> StallE high for exactly 33 cycles, then ALU_ResultM=0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF. RegWriteM stays 0 throughout the stall.
- Special cases with EARLY_SPECIAL=1: DIVU 9/0 -> 0xFFFFFFFF and REM 9/0 -> 9, both with no stall. DIV 0x80000000/-1 -> 0x80000000.
- Abort: assert FlushE at BUSY cycle 10 -> StallE=0 the same cycle, bubble in EX/MEM, and the next DIV runs the full 34 cycles. Repeat the test with rst=0 mid-divide -> all outputs 0.
- Branch: BLT with SrcA=-1, SrcB=1, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120. BLTU with the same operands -> PCSrcE=0.

Source files
------------

// File: rtl/execute_cycle_md.sv
// RV32IM execute stage: operand forwarding, ALU with single-cycle multiply, iterative
// restoring divider, branch/jump resolution and the EX/MEM register feeding the memory stage.
module execute_cycle_md #(
    parameter int XLEN          = 32,
    parameter bit EARLY_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            ALUSrcE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      BranchTypeE,
    input  logic [4:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RD_E,
    input  logic [2:0]      LoadTypeE,
    input  logic [2:0]      StoreTypeE,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            StallE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ALU_ResultM,
    output logic [2:0]      LoadTypeM,
    output logic [2:0]      StoreTypeM
);
    localparam logic [4:0] OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3,  OP_XOR = 5'd4;
    localparam logic [4:0] OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7, OP_SLT = 5'd8;
    localparam logic [4:0] OP_SLTU = 5'd9, OP_MUL = 5'd10, OP_MULH = 5'd11, OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15, OP_REM = 5'd16;
    localparam logic [4:0] OP_REMU = 5'd17;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic            dz_q, dz_d, is_rem_q, is_rem_d;
    logic            reg_write_q, reg_write_d, mem_write_q, mem_write_d;
    logic [1:0]      result_src_q, result_src_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d, write_data_q, write_data_d;
    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [2:0]      load_type_q, load_type_d, store_type_q, store_type_d;

    logic [XLEN-1:0] src_a_s, src_b_raw_s, src_b_s, alu_out_s, ex_result_s;
    logic [63:0]     mul_a_s, mul_b_s, mul_p_s;
    logic            mul_a_sgn_s, mul_b_sgn_s;
    logic            div_op_s, div_signed_s, div_is_rem_s, a_neg_s, b_neg_s;
    logic            div_zero_s, div_ovf_s, early_s, start_s, stall_s, bubble_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s, special_res_s, div_res_s;
    logic [32:0]     part_s;
    logic            part_ge_s, cond_s, pc_src_s, idle_rst_s;
    logic [XLEN-1:0] pc_target_s;

    // Operand forwarding and immediate select.
    always_comb begin
        case (ForwardA_E)
            2'b01:   src_a_s = ResultW;
            2'b10:   src_a_s = alu_result_q;
            default: src_a_s = RD1_E;
        endcase
        case (ForwardB_E)
            2'b01:   src_b_raw_s = ResultW;
            2'b10:   src_b_raw_s = alu_result_q;
            default: src_b_raw_s = RD2_E;
        endcase
        if (ALUSrcE) src_b_s = Imm_Ext_E;
        else         src_b_s = src_b_raw_s;
    end

    // One 64-bit multiplier; operand sign extension picks the MULH* flavour.
    always_comb begin
        mul_a_sgn_s = (ALUControlE == OP_MULH) || (ALUControlE == OP_MULHSU);
        mul_b_sgn_s = (ALUControlE == OP_MULH);
        mul_a_s     = {{32{mul_a_sgn_s & src_a_s[31]}}, src_a_s};
        mul_b_s     = {{32{mul_b_sgn_s & src_b_s[31]}}, src_b_s};
        mul_p_s     = mul_a_s * mul_b_s;
    end

    // Divide operand preparation, special-case detection and early results.
    always_comb begin
        div_op_s      = (ALUControlE >= OP_DIV) && (ALUControlE <= OP_REMU);
        div_signed_s  = (ALUControlE == OP_DIV) || (ALUControlE == OP_REM);
        div_is_rem_s  = (ALUControlE == OP_REM) || (ALUControlE == OP_REMU);
        a_neg_s       = div_signed_s & src_a_s[31];
        b_neg_s       = div_signed_s & src_b_s[31];
        a_mag_s       = a_neg_s ? (32'd0 - src_a_s) : src_a_s;
        b_mag_s       = b_neg_s ? (32'd0 - src_b_s) : src_b_s;
        div_zero_s    = (src_b_s == 32'd0);
        div_ovf_s     = div_signed_s && (src_a_s == 32'h8000_0000) && (src_b_s == 32'hFFFF_FFFF);
        early_s       = EARLY_SPECIAL && div_op_s && (div_zero_s || div_ovf_s);
        if (div_zero_s) special_res_s = div_is_rem_s ? src_a_s : 32'hFFFF_FFFF;
        else            special_res_s = div_is_rem_s ? 32'd0 : 32'h8000_0000;
        start_s       = (state_q == IDLE) && div_op_s && !early_s && !FlushE;
        stall_s       = (start_s || (state_q == BUSY)) && !FlushE;
        part_s        = {rem_q, quo_q[31]};
        part_ge_s     = (part_s >= {1'b0, dvs_q});
        // A zero divisor yields an all-ones magnitude; force the quotient so its sign fixup cannot flip it.
        if (dz_q) div_res_s = is_rem_q ? (neg_rem_q ? 32'd0 - rem_q : rem_q) : 32'hFFFF_FFFF;
        else if (is_rem_q) div_res_s = neg_rem_q ? 32'd0 - rem_q : rem_q;
        else div_res_s = neg_quo_q ? 32'd0 - quo_q : quo_q;
    end

    // ALU operation select; the DONE state substitutes the divider result.
    always_comb begin
        case (ALUControlE)
            OP_SUB:    alu_out_s = src_a_s - src_b_s;
            OP_AND:    alu_out_s = src_a_s & src_b_s;
            OP_OR:     alu_out_s = src_a_s | src_b_s;
            OP_XOR:    alu_out_s = src_a_s ^ src_b_s;
            OP_SLL:    alu_out_s = src_a_s << src_b_s[4:0];
            OP_SRL:    alu_out_s = src_a_s >> src_b_s[4:0];
            OP_SRA:    alu_out_s = $signed(src_a_s) >>> src_b_s[4:0];
            OP_SLT:    alu_out_s = {31'd0, $signed(src_a_s) < $signed(src_b_s)};
            OP_SLTU:   alu_out_s = {31'd0, src_a_s < src_b_s};
            OP_MUL:    alu_out_s = mul_p_s[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: alu_out_s = mul_p_s[63:32];
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_out_s = special_res_s;
            default:   alu_out_s = src_a_s + src_b_s;
        endcase
        if (state_q == DONE) ex_result_s = div_res_s;
        else                 ex_result_s = alu_out_s;
    end

    // Branch condition and target; JALR clears bit 0 of the register-relative target.
    always_comb begin
        case (BranchTypeE)
            3'b000:  cond_s = (src_a_s == src_b_raw_s);
            3'b001:  cond_s = (src_a_s != src_b_raw_s);
            3'b100:  cond_s = ($signed(src_a_s) < $signed(src_b_raw_s));
            3'b101:  cond_s = ($signed(src_a_s) >= $signed(src_b_raw_s));
            3'b110:  cond_s = (src_a_s < src_b_raw_s);
            3'b111:  cond_s = (src_a_s >= src_b_raw_s);
            default: cond_s = 1'b0;
        endcase
        pc_src_s = (JumpE | (BranchE & cond_s)) & ~FlushE;
        if (JumpE && ALUSrcE) pc_target_s = (src_a_s + Imm_Ext_E) & 32'hFFFF_FFFE;
        else                  pc_target_s = PCE + Imm_Ext_E;
        idle_rst_s = (state_q == IDLE) && !rst;
        if (idle_rst_s) begin
            PCSrcE    = 1'b0;
            PCTargetE = 32'd0;
            StallE    = 1'b0;
        end else begin
            PCSrcE    = pc_src_s;
            PCTargetE = pc_target_s;
            StallE    = stall_s;
        end
    end

    // Divider FSM next state and restoring iteration.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        is_rem_d  = is_rem_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d   = BUSY;
                    cnt_d     = 5'd0;
                    quo_d     = a_mag_s;
                    rem_d     = 32'd0;
                    dvs_d     = b_mag_s;
                    neg_quo_d = a_neg_s ^ b_neg_s;
                    neg_rem_d = a_neg_s;
                    dz_d      = div_zero_s;
                    is_rem_d  = div_is_rem_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (FlushE) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = part_ge_s ? (part_s[31:0] - dvs_q) : part_s[31:0];
                    quo_d   = {quo_q[30:0], part_ge_s};
                    cnt_d   = cnt_q + 5'd1;
                    state_d = (cnt_q == 5'd31) ? DONE : BUSY;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // EX/MEM register next value: bubble while stalled or flushed.
    always_comb begin
        bubble_s = stall_s | FlushE;
        if (bubble_s) begin
            reg_write_d = 1'b0;  mem_write_d = 1'b0;  result_src_d = 2'd0; rd_d = 5'd0;
            pc_plus4_d  = 32'd0; write_data_d = 32'd0; alu_result_d = 32'd0;
            load_type_d = 3'd0;  store_type_d = 3'd0;
        end else begin
            reg_write_d = RegWriteE;  mem_write_d = MemWriteE;     result_src_d = ResultSrcE;
            rd_d        = RD_E;       pc_plus4_d  = PCPlus4E;      write_data_d = src_b_raw_s;
            alu_result_d = ex_result_s; load_type_d = LoadTypeE;   store_type_d = StoreTypeE;
        end
    end

    // State and pipeline register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;  cnt_q <= 5'd0;  quo_q <= 32'd0;  rem_q <= 32'd0;  dvs_q <= 32'd0;
            neg_quo_q <= 1'b0; neg_rem_q <= 1'b0; dz_q <= 1'b0; is_rem_q <= 1'b0;
            reg_write_q <= 1'b0; mem_write_q <= 1'b0; result_src_q <= 2'd0; rd_q <= 5'd0;
            pc_plus4_q <= 32'd0; write_data_q <= 32'd0; alu_result_q <= 32'd0;
            load_type_q <= 3'd0; store_type_q <= 3'd0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  quo_q <= quo_d;  rem_q <= rem_d;  dvs_q <= dvs_d;
            neg_quo_q <= neg_quo_d; neg_rem_q <= neg_rem_d; dz_q <= dz_d; is_rem_q <= is_rem_d;
            reg_write_q <= reg_write_d; mem_write_q <= mem_write_d; result_src_q <= result_src_d;
            rd_q <= rd_d; pc_plus4_q <= pc_plus4_d; write_data_q <= write_data_d;
            alu_result_q <= alu_result_d; load_type_q <= load_type_d; store_type_q <= store_type_d;
        end
    end

    assign RegWriteM   = reg_write_q;
    assign MemWriteM   = mem_write_q;
    assign ResultSrcM  = result_src_q;
    assign RD_M        = rd_q;
    assign PCPlus4M    = pc_plus4_q;
    assign WriteDataM  = write_data_q;
    assign ALU_ResultM = alu_result_q;
    assign LoadTypeM   = load_type_q;
    assign StoreTypeM  = store_type_q;
endmodule

// File: tb/tb_execute_cycle_md.sv
// Directed + randomized bench for execute_cycle_md against an arithmetic reference model.
module tb_execute_cycle_md;
    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, FlushE;
    logic [1:0]  ResultSrcE, ForwardA_E, ForwardB_E;
    logic [2:0]  BranchTypeE, LoadTypeE, StoreTypeE;
    logic [4:0]  ALUControlE, RD_E;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic        PCSrcE, StallE, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [2:0]  LoadTypeM, StoreTypeM;

    int checks = 0;
    int errors = 0;

    logic [31:0] sa, sbr, sb, exp_m, exp_r;
    logic [4:0]  op;
    logic [2:0]  bt;
    logic [2:0]  bt_tab [6];
    logic [31:0] da, db;
    int          est;

    execute_cycle_md #(.XLEN(32), .EARLY_SPECIAL(1'b1)) dut (
        .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE), .BranchTypeE(BranchTypeE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RD_E(RD_E), .LoadTypeE(LoadTypeE), .StoreTypeE(StoreTypeE),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW), .FlushE(FlushE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .LoadTypeM(LoadTypeM),
        .StoreTypeM(StoreTypeM)
    );

    always #5 clk = ~clk;

    // Reference result of one operation, written with plain integer arithmetic.
    function automatic logic [31:0] ref_alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        int          ai, bi;
        longint      xa, xb, ua, ub;
        logic [63:0] pv;
        ai = a; bi = b; xa = ai; xb = bi; ua = {32'd0, a}; ub = {32'd0, b};
        case (f)
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return a << b[4:0];
            5'd6:  return a >> b[4:0];
            5'd7:  begin pv = xa >>> b[4:0]; return pv[31:0]; end
            5'd8:  return (xa < xb) ? 32'd1 : 32'd0;
            5'd9:  return (ua < ub) ? 32'd1 : 32'd0;
            5'd10: begin pv = xa * xb; return pv[31:0]; end
            5'd11: begin pv = xa * xb; return pv[63:32]; end
            5'd12: begin pv = xa * ub; return pv[63:32]; end
            5'd13: begin pv = {32'd0, a} * {32'd0, b}; return pv[63:32]; end
            5'd14: begin if (b == 32'd0) return 32'hFFFF_FFFF; pv = xa / xb; return pv[31:0]; end
            5'd15: begin if (b == 32'd0) return 32'hFFFF_FFFF; pv = ua / ub; return pv[31:0]; end
            5'd16: begin if (b == 32'd0) return a; pv = xa % xb; return pv[31:0]; end
            5'd17: begin if (b == 32'd0) return a; pv = ua % ub; return pv[31:0]; end
            default: return a + b;
        endcase
    endfunction

    function automatic bit ref_take(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        int ai, bi;
        ai = a; bi = b;
        case (t)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return ai < bi;
            3'b101:  return ai >= bi;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        RegWriteE = 1'b0; MemWriteE = 1'b0; ALUSrcE = 1'b0; BranchE = 1'b0; JumpE = 1'b0;
        FlushE = 1'b0; ResultSrcE = 2'd0; ForwardA_E = 2'd0; ForwardB_E = 2'd0; BranchTypeE = 3'd0;
        LoadTypeE = 3'd0; StoreTypeE = 3'd0; ALUControlE = 5'd0; RD_E = 5'd0; RD1_E = 32'd0;
        RD2_E = 32'd0; Imm_Ext_E = 32'd0; PCE = 32'd0; PCPlus4E = 32'd0; ResultW = 32'd0;
    endtask

    // Issue one divide, count stall cycles (bounded) and check the written-back result.
    task automatic run_div(input string tag, input logic [4:0] f, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stall);
        int stalls;
        bit rw_bad;
        clear_in();
        ALUControlE = f; RD1_E = a; RD2_E = b; RegWriteE = 1'b1; RD_E = 5'd9;
        #1;
        stalls = 0;
        rw_bad = 1'b0;
        while (StallE === 1'b1 && stalls < 100) begin
            stalls++;
            tick();
            if (RegWriteM !== 1'b0) rw_bad = 1'b1;
        end
        chk({tag, "_stall_cycles"}, stalls, exp_stall);
        chk({tag, "_regwrite_in_stall"}, {31'd0, rw_bad}, 32'd0);
        tick();
        chk({tag, "_result"}, ALU_ResultM, ref_alu(f, a, b));
        chk({tag, "_regwrite"}, {31'd0, RegWriteM}, 32'd1);
        clear_in();
    endtask

    initial begin
        bt_tab[0] = 3'b000; bt_tab[1] = 3'b001; bt_tab[2] = 3'b100;
        bt_tab[3] = 3'b101; bt_tab[4] = 3'b110; bt_tab[5] = 3'b111;

        // Reset with busy-looking inputs; everything must read zero.
        clear_in();
        rst = 1'b0;
        RegWriteE = 1'b1; MemWriteE = 1'b1; RD1_E = 32'h1234; RD2_E = 32'h55; RD_E = 5'd3;
        JumpE = 1'b1; BranchE = 1'b1; PCE = 32'h40; Imm_Ext_E = 32'h4; PCPlus4E = 32'h44;
        tick();
        tick();
        chk("rst_regwrite", {31'd0, RegWriteM}, 32'd0);
        chk("rst_memwrite", {31'd0, MemWriteM}, 32'd0);
        chk("rst_alu", ALU_ResultM, 32'd0);
        chk("rst_pcplus4", PCPlus4M, 32'd0);
        chk("rst_stall", {31'd0, StallE}, 32'd0);
        chk("rst_pcsrc", {31'd0, PCSrcE}, 32'd0);
        chk("rst_pctarget", PCTargetE, 32'd0);

        // Forwarding from ALU_ResultM.
        clear_in();
        rst = 1'b1;
        ALUControlE = 5'd0; RD1_E = 32'd2; RD2_E = 32'd3; RegWriteE = 1'b1;
        tick();
        chk("add_base", ALU_ResultM, 32'd5);
        ForwardA_E = 2'b10; RD1_E = 32'hDEAD; RD2_E = 32'd7; RD_E = 5'd5;
        tick();
        chk("fwd_add", ALU_ResultM, 32'd12);
        chk("fwd_regwrite", {31'd0, RegWriteM}, 32'd1);
        chk("fwd_rd", {27'd0, RD_M}, 32'd5);
        chk("fwd_wdata", WriteDataM, 32'd7);

        // High-half multiplies.
        clear_in();
        RegWriteE = 1'b1; ALUControlE = 5'd11; RD1_E = 32'h8000_0000; RD2_E = 32'd2;
        tick();
        chk("mulh", ALU_ResultM, 32'hFFFF_FFFF);
        ALUControlE = 5'd13;
        tick();
        chk("mulhu", ALU_ResultM, 32'h0000_0001);
        exp_m = 32'd1;

        // Directed branches, JALR and flush.
        clear_in();
        BranchE = 1'b1; BranchTypeE = 3'b100; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
        PCE = 32'h100; Imm_Ext_E = 32'h20;
        #1;
        chk("blt_taken", {31'd0, PCSrcE}, 32'd1);
        chk("blt_target", PCTargetE, 32'h120);
        BranchTypeE = 3'b110;
        #1;
        chk("bltu_not_taken", {31'd0, PCSrcE}, 32'd0);
        BranchE = 1'b0; JumpE = 1'b1; ALUSrcE = 1'b1; RD1_E = 32'h1001;
        #1;
        chk("jalr_taken", {31'd0, PCSrcE}, 32'd1);
        chk("jalr_target", PCTargetE, 32'h1020);
        FlushE = 1'b1; RegWriteE = 1'b1;
        #1;
        chk("flush_pcsrc", {31'd0, PCSrcE}, 32'd0);
        tick();
        chk("flush_bubble", {31'd0, RegWriteM}, 32'd0);
        exp_m = 32'd0;

        // Randomized ALU/multiply/branch stream against the reference model.
        for (int i = 0; i < 40; i++) begin
            clear_in();
            est = int'($urandom_range(0, 27));
            op = (est < 14) ? 5'(est) : 5'(est + 4);
            ALUControlE = op;
            RD1_E = $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom; ResultW = $urandom;
            PCE = $urandom; PCPlus4E = $urandom;
            ForwardA_E = 2'($urandom_range(0, 2)); ForwardB_E = 2'($urandom_range(0, 2));
            ALUSrcE = 1'($urandom_range(0, 1)); RegWriteE = 1'($urandom_range(0, 1));
            BranchE = 1'($urandom_range(0, 1)); bt = bt_tab[$urandom_range(0, 5)];
            BranchTypeE = bt;
            if (i % 5 == 0) RD2_E = RD1_E;
            sa  = (ForwardA_E == 2'b01) ? ResultW : (ForwardA_E == 2'b10) ? exp_m : RD1_E;
            sbr = (ForwardB_E == 2'b01) ? ResultW : (ForwardB_E == 2'b10) ? exp_m : RD2_E;
            sb  = ALUSrcE ? Imm_Ext_E : sbr;
            exp_r = ref_alu(op, sa, sb);
            #1;
            chk("rnd_pcsrc", {31'd0, PCSrcE}, {31'd0, BranchE & ref_take(bt, sa, sbr)});
            chk("rnd_target", PCTargetE, PCE + Imm_Ext_E);
            da = PCPlus4E;
            db = {31'd0, RegWriteE};
            tick();
            chk("rnd_alu", ALU_ResultM, exp_r);
            chk("rnd_wdata", WriteDataM, sbr);
            chk("rnd_regwrite", {31'd0, RegWriteM}, db);
            chk("rnd_pcplus4", PCPlus4M, da);
            exp_m = exp_r;
        end

        // Iterative divide: full 33-cycle stall and signed fixup.
        run_div("div_m7_2", 5'd14, 32'hFFFF_FFF9, 32'd2, 33);
        run_div("rem_m7_2", 5'd16, 32'hFFFF_FFF9, 32'd2, 33);
        run_div("divu_9_0", 5'd15, 32'd9, 32'd0, 0);
        run_div("rem_9_0", 5'd16, 32'd9, 32'd0, 0);
        run_div("div_ovf", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        for (int k = 0; k < 4; k++) begin
            op = 5'(14 + k);
            da = $urandom;
            db = $urandom >> $urandom_range(0, 31);
            est = (db == 32'd0) ? 0 : 33;
            run_div("div_rnd", op, da, db, est);
        end

        // Abort with FlushE in BUSY, then a fresh divide runs in full.
        clear_in();
        ALUControlE = 5'd14; RD1_E = 32'hFFFF_FF9C; RD2_E = 32'd7; RegWriteE = 1'b1;
        #1;
        chk("abort_start_stall", {31'd0, StallE}, 32'd1);
        tick();
        repeat (10) tick();
        FlushE = 1'b1;
        #1;
        chk("abort_stall_drop", {31'd0, StallE}, 32'd0);
        tick();
        chk("abort_bubble_rw", {31'd0, RegWriteM}, 32'd0);
        chk("abort_bubble_alu", ALU_ResultM, 32'd0);
        run_div("after_abort", 5'd14, 32'hFFFF_FF9C, 32'd7, 33);

        // Reset in the middle of a divide.
        clear_in();
        ALUControlE = 5'd17; RD1_E = 32'd1000; RD2_E = 32'd33; RegWriteE = 1'b1;
        PCE = 32'h200; Imm_Ext_E = 32'h10; JumpE = 1'b1;
        tick();
        repeat (5) tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_rw", {31'd0, RegWriteM}, 32'd0);
        chk("mid_rst_alu", ALU_ResultM, 32'd0);
        chk("mid_rst_stall", {31'd0, StallE}, 32'd0);
        chk("mid_rst_pcsrc", {31'd0, PCSrcE}, 32'd0);
        chk("mid_rst_target", PCTargetE, 32'd0);
        clear_in();
        rst = 1'b1;
        tick();
        run_div("after_rst", 5'd17, 32'd1000, 32'd33, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
